uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single SoC UART transmitter (the serializer driving uart_tx) between NUM_REQ byte-stream requesters, e.g. the CPU MMIO port and the debug monitor.
- Arbitrates round-robin at packet granularity: a grant is held until the requester's last byte or an idle timeout.
- Drives the serializer through one registered valid/ready byte stage.
- Sits between the requesters and the UART TX serializer inside ayatsuki_soc.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT, 1023, max consecutive cycles the granted requester may hold req_valid low mid-packet before the grant is revoked (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_W  per-requester byte, requester i at [i*DATA_W +: DATA_W]
req_last  input  NUM_REQ  byte is last of packet
req_ready  output  NUM_REQ  per-requester accept
tx_valid  output  1  byte valid to serializer (registered)
tx_data  output  DATA_W  byte to serializer (registered)
tx_ready  input  1  serializer accepts byte
grant_id  output  GID_W  current/last winner, GID_W = max(1, clog2(NUM_REQ))
busy  output  1  high in GRANT state or while tx_valid is high
timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async, rst=1): state=IDLE, rr pointer=0, grant_id=0, tx_valid=0, tx_data=0, req_ready=0, timeout_pulse=0, idle counter=0. Reset mid-packet drops any held byte; the byte is not replayed.
- FSM IDLE:
  - req_ready all 0.
  - If any req_valid: pick the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Register the winner into grant_id; go to GRANT next cycle. Arbitration latency is 1 cycle.
- FSM GRANT, g = grant_id:
  - req_ready[g] = (!tx_valid || tx_ready). All other req_ready bits are 0.
  - Accept = req_valid[g] && req_ready[g]. On accept: tx_data <= req_data[g], tx_valid <= 1.
  - Accept with req_last[g]=1: go to IDLE; rr pointer <= (g+1) mod NUM_REQ.
- Output stage:
  - tx_valid clears on tx_ready when there is no same-cycle accept.
  - Accept and tx_ready in the same cycle: register reloads, tx_valid stays 1, full throughput of 1 byte/cycle.
  - tx_data is stable while tx_valid && !tx_ready.
- Draining: leaving GRANT does not wait for the output register to drain. The next arbitration overlaps the drain; the new grant's first accept waits on the req_ready condition.
- Timeout:
  - In GRANT, the idle counter increments on cycles with req_valid[g]=0 and clears on req_valid[g]=1. Cycles stalled by tx_ready do not count.
  - When the counter reaches TIMEOUT: go to IDLE, pulse timeout_pulse, rr pointer <= g+1. No byte is accepted in that cycle.
  - Counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- Latency: req_valid asserted in IDLE at cycle n (empty output register) -> req_ready high at n+1 -> tx_valid high at n+2.
- Simultaneous requests: resolved only by the rr pointer, never by index. A requester dropping req_valid before being granted loses nothing.
- busy = (state==GRANT) || tx_valid.

Decomposition:
- Shared defines header: FSM state encodings (ST_IDLE, ST_GRANT) and the GID_W computation macro, reused by future UART RX/DMA arbiters.
- One sub-module, uart_rr_pick: combinational rotating-priority picker. Inputs: request vector and pointer. Outputs: winner index and any-hit.

Test Plan:
1. Single requester: req 0 sends bytes 0x41,0x42 (last on 0x42), tx_ready=1 -> tx_data 0x41 at cycle n+2, 0x42 at n+3; FSM returns to IDLE; rr pointer=1.
2. Contention: req 0 and req 1 both valid from reset release, each a 2-byte packet -> packet order req0,req1. Repeat with both valid -> order req1,req0 after the pointer rotation; bytes never interleave within a packet.
3. Backpressure: tx_ready=0 for 5 cycles with tx_valid=1, tx_data=0x55 -> tx_data held 0x55, req_ready[g]=0; after tx_ready=1 the next byte follows with no bubble.
4. Timeout with TIMEOUT=4: req 1 sends a non-last byte then deasserts valid -> timeout_pulse high exactly once after 4 idle cycles; pending req 0 granted on the next cycle.
5. Reset mid-packet: rst pulse while tx_valid=1 and in GRANT -> all outputs zero asynchronously; after release a new request is granted from pointer 0.
6. NUM_REQ=3 wrap: requests on 0 and 2 with pointer=2 -> grant 2 then 0; grant_id never reaches an invalid index.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART arbiters: FSM state encoding and grant-index width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Grant index width: max(1, clog2(n)).
  function automatic int unsigned gid_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GID_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   ptr,
  output logic [GID_W-1:0]   idx,
  output logic               hit
);

  // Two linear passes (ptr..top, then 0..top) instead of a modulo index.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i] && (i >= 32'(ptr))) begin
        hit = 1'b1;
        idx = GID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i]) begin
        hit = 1'b1;
        idx = GID_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX serializer among NUM_REQ
// byte-stream requesters, with idle-timeout grant revocation and one registered output stage.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned GID_W   = gid_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_pulse
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e         r_state, w_state_nxt;
  logic [GID_W-1:0]   r_ptr, r_gid, w_pick, w_gid_inc;
  logic               w_hit;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic               r_tx_valid;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_to_pulse;
  logic               w_sel_valid, w_sel_last;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_slot_free, w_timeout, w_accept;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .GID_W  (GID_W)
  ) u_pick (
    .req(req_valid),
    .ptr(r_ptr),
    .idx(w_pick),
    .hit(w_hit)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(r_gid) == i) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_gid_inc   = (32'(r_gid) == NUM_REQ - 1) ? '0 : r_gid + 1'b1;
  assign w_slot_free = !r_tx_valid || tx_ready;
  assign w_timeout   = (r_state == ST_GRANT) && (r_idle_cnt == CNT_W'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(r_gid) == i) req_ready[i] = w_slot_free;
          end
          w_accept = w_sel_valid && w_slot_free;
          if (w_accept && w_sel_last) w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_gid      <= '0;
      r_idle_cnt <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_pulse <= w_timeout;
      if (r_state == ST_IDLE && w_hit) r_gid <= w_pick;
      if (w_timeout || (w_accept && w_sel_last)) r_ptr <= w_gid_inc;
      // Counts only cycles where the grantee has nothing to offer; saturates at TIMEOUT.
      if (r_state != ST_GRANT || w_sel_valid) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != CNT_W'(TIMEOUT)) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
      if (w_accept) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_sel_data;
      end else if (tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign tx_valid      = r_tx_valid;
  assign tx_data       = r_tx_data;
  assign grant_id      = r_gid;
  assign timeout_pulse = r_to_pulse;
  assign busy          = (r_state == ST_GRANT) || r_tx_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (3 requesters, TIMEOUT=4): expected bytes are queued
// in predicted arbitration order at stimulus time and popped at each serializer handshake.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;
  localparam int unsigned GW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              tx_valid;
  logic [DW-1:0]     tx_data;
  logic              tx_ready;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              timeout_pulse;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [8:0]   q0[$], q1[$], q2[$];
  logic [7:0]   sb[$];
  logic [NR-1:0] acc;
  logic         rdy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsize(input int r);
    case (r)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [8:0] qfront(input int r);
    case (r)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int r);
    case (r)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  // Callers send packets in the order the arbiter is expected to serve them.
  task automatic send(input int r, input logic [7:0] d, input logic l);
    case (r)
      0:       q0.push_back({l, d});
      1:       q1.push_back({l, d});
      default: q2.push_back({l, d});
    endcase
    sb.push_back(d);
  endtask

  task automatic clear_bench();
    q0.delete(); q1.delete(); q2.delete(); sb.delete();
    acc       = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
  endtask

  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (acc[i]) qpop(i);
    for (int i = 0; i < NR; i++) begin
      e = (qsize(i) > 0) ? qfront(i) : 9'd0;
      req_valid[i]          = (qsize(i) > 0);
      req_last[i]           = e[8];
      req_data[i*DW +: DW]  = e[7:0];
    end
    tx_ready = rdy;
    #1;
    for (int i = 0; i < NR; i++) acc[i] = req_valid[i] && req_ready[i];
    if (tx_valid && tx_ready) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(sb.pop_front()));
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || (qsize(0) + qsize(1) + qsize(2)) != 0) && n < 60) begin
      step();
      n++;
      check_eq("gid_range", 32'(grant_id < NR), 32'd1);
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bench();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; tx_ready = 1'b1;
    clear_bench();
    #1 rst = 1'b1;
    #2;
    check_eq("rst_gid",   32'(grant_id),      32'd0);
    check_eq("rst_txv",   32'(tx_valid),      32'd0);
    check_eq("rst_txd",   32'(tx_data),       32'd0);
    check_eq("rst_ready", 32'(req_ready),     32'd0);
    check_eq("rst_pulse", 32'(timeout_pulse), 32'd0);
    check_eq("rst_busy",  32'(busy),          32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester latency and return to idle
    send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b1);
    step(); check_eq("t1_ready_n",  32'(req_ready), 32'd0);
    step(); check_eq("t1_ready_n1", 32'(req_ready), 32'b001);
            check_eq("t1_txv_n1",   32'(tx_valid),  32'd0);
    step(); check_eq("t1_txv_n2",   32'(tx_valid),  32'd1);
    step(); check_eq("t1_txv_n3",   32'(tx_valid),  32'd1);
    step(); check_eq("t1_busy_end", 32'(busy),      32'd0);

    // Contention from reset: 0 then 1; pointer 2 picks 2 before 0; pointer 1 picks 1 before 0
    do_reset();
    send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b1);
    send(1, 8'h11, 1'b0); send(1, 8'h12, 1'b1);
    wait_drain("t2_round1");
    send(2, 8'h23, 1'b0); send(2, 8'h24, 1'b1);
    send(0, 8'h03, 1'b0); send(0, 8'h04, 1'b1);
    wait_drain("t2_round2");
    send(1, 8'h15, 1'b0); send(1, 8'h16, 1'b1);
    send(0, 8'h05, 1'b0); send(0, 8'h06, 1'b1);
    wait_drain("t2_round3");

    // Backpressure: held byte, no ready, then no bubble
    rdy = 1'b0;
    send(0, 8'h55, 1'b0); send(0, 8'h56, 1'b0); send(0, 8'h57, 1'b1);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t3_hold_data",  32'(tx_data),   32'h55);
      check_eq("t3_hold_ready", 32'(req_ready), 32'd0);
    end
    rdy = 1'b1;
    step(); check_eq("t3_resume_ready", 32'(req_ready), 32'b001);
    step(); check_eq("t3_no_bubble",    32'(tx_valid),  32'd1);
    wait_drain("t3_drain");

    // Timeout: req 1 stalls mid-packet, req 0 pending
    send(1, 8'h21, 1'b0); send(0, 8'h0A, 1'b1);
    step();
    step(); check_eq("t4_gid1",   32'(grant_id),  32'd1);
            check_eq("t4_ready1", 32'(req_ready), 32'b010);
    for (int k = 2; k <= 6; k++) begin
      step();
      check_eq("t4_no_pulse", 32'(timeout_pulse), 32'd0);
    end
    check_eq("t4_revoke_ready", 32'(req_ready), 32'd0);
    step(); check_eq("t4_pulse",     32'(timeout_pulse), 32'd1);
    step(); check_eq("t4_pulse_end", 32'(timeout_pulse), 32'd0);
            check_eq("t4_gid0",      32'(grant_id),      32'd0);
            check_eq("t4_ready0",    32'(req_ready),     32'b001);
    wait_drain("t4_drain");

    // Reset mid-packet, then arbitration restarts from pointer 0
    rdy = 1'b0;
    send(2, 8'h31, 1'b0); send(2, 8'h32, 1'b0); send(2, 8'h33, 1'b1);
    step(); step(); step();
    check_eq("t5_pre_txv",  32'(tx_valid), 32'd1);
    check_eq("t5_pre_busy", 32'(busy),     32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_txv",   32'(tx_valid),      32'd0);
    check_eq("t5_txd",   32'(tx_data),       32'd0);
    check_eq("t5_ready", 32'(req_ready),     32'd0);
    check_eq("t5_gid",   32'(grant_id),      32'd0);
    check_eq("t5_busy",  32'(busy),          32'd0);
    check_eq("t5_pulse", 32'(timeout_pulse), 32'd0);
    clear_bench();
    rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(0, 8'h0B, 1'b1); send(2, 8'h3C, 1'b1);
    step(); step();
    check_eq("t5_gid_after", 32'(grant_id), 32'd0);
    wait_drain("t5_drain");

    check_eq("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
